floo_credit_link: RTL and testbench
===================================

FLOO_CREDIT_LINK -- requirements
Module: floo_credit_link

Interface
REQ-001: Parameter flit_t, default logic, type of one link flit (transported opaquely).
REQ-002: Parameter NumCredits, default 4, number of rx buffer slots and initial tx credits; legal range >= 1.
REQ-003: Derived CntWidth = $clog2(NumCredits+1), width of the tx credit counter.
REQ-004: One clock; reset is asynchronous and active-low; ports clk_i and rst_ni.
REQ-005: clk_i  input  1  clock.
REQ-006: rst_ni  input  1  asynchronous active-low reset.
REQ-007: valid_i  input  1  tx flit valid from upstream router output.
REQ-008: ready_o  output  1  tx ready to upstream router output.
REQ-009: data_i  input  flit_t  tx flit from upstream router output.
REQ-010: link_valid_o  output  1  flit valid on outgoing physical link.
REQ-011: link_data_o  output  flit_t  flit on outgoing physical link.
REQ-012: link_credit_i  input  1  one-cycle credit-return pulse from far receiver.
REQ-013: link_valid_i  input  1  flit valid on incoming physical link.
REQ-014: link_data_i  input  flit_t  flit on incoming physical link.
REQ-015: link_credit_o  output  1  one-cycle credit-return pulse to far sender.
REQ-016: valid_o  output  1  rx flit valid to downstream router input.
REQ-017: ready_i  input  1  rx ready from downstream router input.
REQ-018: data_o  output  flit_t  rx flit to downstream router input.

Function
REQ-019: Tx and rx halves are independent; they share only clk_i/rst_ni.
REQ-020: Tx ready_o = (credit counter != 0); ready_o does not depend on valid_i.
REQ-021: Tx handshake = valid_i && ready_o; on handshake, link_valid_o = 1 and link_data_o = data_i in the next cycle (latency 1, registered).
REQ-022: Without handshake, link_valid_o = 0 next cycle; link_data_o holds its last value.
REQ-023: Counter next = cnt - handshake + link_credit_i; handshake and credit in the same cycle leave it unchanged.
REQ-024: Credit with cnt == NumCredits and no handshake is a protocol error: counter saturates at NumCredits; simulation assertion fires.
REQ-025: Rx FIFO depth NumCredits; link_valid_i pushes link_data_i unconditionally (no back-pressure on link).
REQ-026: valid_o = FIFO not empty; data_o = FIFO head; a pushed flit is visible on valid_o the cycle after push (no fall-through).
REQ-027: Pop on valid_o && ready_i; link_credit_o = 1 exactly in the cycle after each pop, else 0.
REQ-028: Push and pop in the same cycle are legal at any fill level including full; occupancy unchanged.
REQ-029: Push when full without pop is a protocol error: flit dropped, FIFO state unchanged, assertion fires.
REQ-030: Read/write pointers wrap from NumCredits-1 to 0; FIFO order preserved across wrap.
REQ-031: Two instances in loopback (link_valid_o->link_valid_i, link_credit_o->link_credit_i) with ready_i = 1 sustain one flit per cycle for NumCredits >= 4 (credit round trip 4 cycles).

Reset
REQ-032: While rst_ni = 0: credit counter = NumCredits, ready_o = 1, link_valid_o = 0, link_data_o = '0, FIFO empty, valid_o = 0, link_credit_o = 0.
REQ-033: Reset asserted mid-operation discards all buffered flits and in-flight credit state immediately (asynchronous); no link_credit_o pulse is emitted for discarded flits.
REQ-034: Both link ends are reset together; credit consistency across independent resets is out of scope.

Verification
REQ-035: Reset release, NumCredits=4, valid_i=1 continuously, no credits -> exactly 4 handshakes, link_valid_o high 4 cycles, then ready_o = 0.
REQ-036: Counter at 0, link_credit_i pulse -> ready_o = 1 next cycle; with valid_i = 1, one further flit sent, ready_o returns to 0.
REQ-037: Counter at 2, handshake and link_credit_i in same cycle -> counter stays 2, ready_o stays 1.
REQ-038: Rx push 4 flits A,B,C,D with ready_i=0 -> valid_o=1, data_o=A; then ready_i=1 -> A,B,C,D in order on 4 consecutive cycles, 4 link_credit_o pulses each 1 cycle after its pop.
REQ-039: Rx full, push E and pop in same cycle -> no drop, no assertion, E delivered after D; push when full without pop -> assertion, flit dropped.
REQ-040: Loopback, NumCredits=4, ready_i=1, 100 random flits -> 100 flits out in order, no stall after pipeline fill, counter returns to 4; repeat with random ready_i -> no loss, no assertion.

Source files
------------

// File: rtl/floo_credit_link.sv
// Credit-based point-to-point link endpoint: a registered tx stage gated by a
// credit counter, and an rx buffer that returns one credit per consumed flit.

module floo_credit_link_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic credit_err_i,
    input logic overflow_err_i
);

    // Flags link protocol violations observed by the endpoint
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!credit_err_i) else $error("credit returned while counter at maximum");
            assert (!overflow_err_i) else $error("flit pushed into full rx buffer");
        end
    end

endmodule

module floo_credit_link #(
    parameter type         flit_t     = logic,
    parameter int unsigned NumCredits = 4,
    parameter bit          AssertEn   = 1'b1
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  valid_i,
    output logic  ready_o,
    input  flit_t data_i,
    output logic  link_valid_o,
    output flit_t link_data_o,
    input  logic  link_credit_i,
    input  logic  link_valid_i,
    input  flit_t link_data_i,
    output logic  link_credit_o,
    output logic  valid_o,
    input  logic  ready_i,
    output flit_t data_o
);

    localparam int unsigned CntWidth = $clog2(NumCredits + 1);
    localparam int unsigned PtrWidth = (NumCredits > 1) ? $clog2(NumCredits) : 1;
    localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(NumCredits);
    localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
    localparam logic [CntWidth-1:0] CntZero = CntWidth'(0);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(NumCredits - 1);
    localparam logic [PtrWidth-1:0] PtrOne  = PtrWidth'(1);
    localparam logic [PtrWidth-1:0] PtrZero = PtrWidth'(0);

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
        return (ptr == LastPtr) ? PtrZero : ptr + PtrOne;
    endfunction

    // ---------------- tx half ----------------
    logic [CntWidth-1:0] cnt_d, cnt_q;
    logic                link_valid_q;
    flit_t               link_data_q;
    logic                tx_hs_s;
    logic                credit_err_s;

    assign ready_o      = (cnt_q != CntZero);
    assign tx_hs_s      = valid_i && ready_o;
    assign credit_err_s = link_credit_i && !tx_hs_s && (cnt_q == MaxCnt);
    assign link_valid_o = link_valid_q;
    assign link_data_o  = link_data_q;

    // Credit counter next state; a surplus credit saturates at the maximum
    always_comb begin
        cnt_d = cnt_q;
        case ({tx_hs_s, link_credit_i})
            2'b10: cnt_d = cnt_q - CntOne;
            2'b01: begin
                if (credit_err_s) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // Tx credit counter and outgoing link register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= MaxCnt;
            link_valid_q <= 1'b0;
            link_data_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            link_valid_q <= tx_hs_s;
            if (tx_hs_s) begin
                link_data_q <= data_i;
            end
        end
    end

    // ---------------- rx half ----------------
    flit_t               mem_q [NumCredits];
    logic [PtrWidth-1:0] wptr_d, wptr_q, rptr_d, rptr_q;
    logic [CntWidth-1:0] fill_d, fill_q;
    logic                credit_q;
    logic                pop_s, push_s, overflow_s;

    assign valid_o       = (fill_q != CntZero);
    assign data_o        = mem_q[rptr_q];
    assign link_credit_o = credit_q;
    assign pop_s         = valid_o && ready_i;
    // Popping frees the slot in the same cycle, so a full buffer still accepts then
    assign overflow_s    = link_valid_i && (fill_q == MaxCnt) && !pop_s;
    assign push_s        = link_valid_i && !overflow_s;

    // Rx pointer and occupancy next state
    always_comb begin
        wptr_d = push_s ? next_ptr(wptr_q) : wptr_q;
        rptr_d = pop_s ? next_ptr(rptr_q) : rptr_q;
        fill_d = fill_q;
        case ({push_s, pop_s})
            2'b10:   fill_d = fill_q + CntOne;
            2'b01:   fill_d = fill_q - CntOne;
            default: fill_d = fill_q;
        endcase
    end

    // Rx control state and credit-return pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q   <= PtrZero;
            rptr_q   <= PtrZero;
            fill_q   <= CntZero;
            credit_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            fill_q   <= fill_d;
            credit_q <= pop_s;
        end
    end

    // Rx buffer storage; contents are only meaningful while occupancy covers them
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wptr_q] <= link_data_i;
        end
    end

    if (AssertEn) begin : gen_chk
        floo_credit_link_chk i_chk (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .credit_err_i   (credit_err_s),
            .overflow_err_i (overflow_s)
        );
    end

endmodule

// File: tb/tb_floo_credit_link.sv
// Directed bench for floo_credit_link: tx credit flow, rx buffering, reset,
// and a loopback pair carrying random flits.

module tb_floo_credit_link;

    logic       clk_i;
    logic       rst_ni;
    logic       valid_i, ready_o, link_valid_o, link_credit_i;
    logic       link_valid_i, link_credit_o, valid_o, ready_i;
    logic [7:0] data_i, link_data_o, link_data_i, data_o;

    logic       lb_valid, lb_ready, lb_a_ready;
    logic [7:0] lb_data;
    logic       ab_valid, ba_valid, ab_credit, ba_credit;
    logic [7:0] ab_data, ba_data;
    logic       lb_a_valid_o, lb_b_ready_o, lb_b_valid_o;
    logic [7:0] lb_a_data_o, lb_b_data_o;

    int errors = 0;
    int checks = 0;

    floo_credit_link #(.flit_t(logic [7:0]), .NumCredits(4), .AssertEn(1'b0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .link_valid_o(link_valid_o), .link_data_o(link_data_o), .link_credit_i(link_credit_i),
        .link_valid_i(link_valid_i), .link_data_i(link_data_i), .link_credit_o(link_credit_o),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o)
    );

    floo_credit_link #(.flit_t(logic [7:0]), .NumCredits(4)) lb_a (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .valid_i(lb_valid), .ready_o(lb_a_ready), .data_i(lb_data),
        .link_valid_o(ab_valid), .link_data_o(ab_data), .link_credit_i(ba_credit),
        .link_valid_i(ba_valid), .link_data_i(ba_data), .link_credit_o(ab_credit),
        .valid_o(lb_a_valid_o), .ready_i(1'b1), .data_o(lb_a_data_o)
    );

    floo_credit_link #(.flit_t(logic [7:0]), .NumCredits(4)) lb_b (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .valid_i(1'b0), .ready_o(lb_b_ready_o), .data_i(8'h00),
        .link_valid_o(ba_valid), .link_data_o(ba_data), .link_credit_i(ab_credit),
        .link_valid_i(ab_valid), .link_data_i(ab_data), .link_credit_o(ba_credit),
        .valid_o(lb_b_valid_o), .ready_i(lb_ready), .data_o(lb_b_data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        logic [7:0] flits [100];
        logic [7:0] exp6 [4];
        int hs_n, tx_n, rx_n, stalls, cyc;
        logic hs;

        valid_i = 1'b0; data_i = 8'h00; link_credit_i = 1'b0;
        link_valid_i = 1'b0; link_data_i = 8'h00; ready_i = 1'b0;
        lb_valid = 1'b0; lb_data = 8'h00; lb_ready = 1'b1;
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        tick; tick;
        chk("rst_ready", ready_o, 1);
        chk("rst_link_valid", link_valid_o, 0);
        chk("rst_link_data", link_data_o, 0);
        chk("rst_valid_o", valid_o, 0);
        chk("rst_credit_o", link_credit_o, 0);
        rst_ni = 1'b1;

        // Four credits, continuous valid, no returns
        valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_i = 8'h10 + 8'(i);
            chk("tx_ready_seq", ready_o, (i < 4) ? 1 : 0);
            tick;
            chk("tx_link_valid_seq", link_valid_o, (i < 4) ? 1 : 0);
            if (i < 4) chk("tx_link_data_seq", link_data_o, 8'h10 + 8'(i));
        end
        chk("tx_data_hold", link_data_o, 8'h13);
        valid_i = 1'b0;

        // Single credit at zero count
        link_credit_i = 1'b1; tick; link_credit_i = 1'b0;
        chk("tx_credit_ready", ready_o, 1);
        valid_i = 1'b1; data_i = 8'hA5; tick; valid_i = 1'b0;
        chk("tx_credit_flit_valid", link_valid_o, 1);
        chk("tx_credit_flit_data", link_data_o, 8'hA5);
        chk("tx_credit_ready_off", ready_o, 0);

        // Count 2: handshake and credit together
        link_credit_i = 1'b1; tick; tick;
        valid_i = 1'b1; data_i = 8'h5A; tick;
        link_credit_i = 1'b0;
        chk("tx_hs_credit_ready", ready_o, 1);
        chk("tx_hs_credit_data", link_data_o, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            chk("tx_count2_ready", ready_o, (i < 2) ? 1 : 0);
            tick;
        end
        valid_i = 1'b0;

        // Surplus credit saturates at four
        link_credit_i = 1'b1;
        repeat (5) tick;
        link_credit_i = 1'b0;
        valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("tx_sat_ready", ready_o, (i < 4) ? 1 : 0);
            tick;
        end
        valid_i = 1'b0;

        // Rx: four pushes held, then drained in order
        chk("rx_empty", valid_o, 0);
        for (int k = 0; k < 4; k++) begin
            link_valid_i = 1'b1; link_data_i = 8'hA0 + 8'(k);
            tick;
            chk("rx_fill_valid", valid_o, 1);
            chk("rx_fill_head", data_o, 8'hA0);
            chk("rx_fill_no_credit", link_credit_o, 0);
        end
        link_valid_i = 1'b0;
        ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("rx_drain_data", data_o, 8'hA0 + 8'(k));
            chk("rx_drain_valid", valid_o, 1);
            chk("rx_drain_credit", link_credit_o, (k > 0) ? 1 : 0);
            tick;
        end
        chk("rx_last_credit", link_credit_o, 1);
        chk("rx_drained", valid_o, 0);
        ready_i = 1'b0; tick;
        chk("rx_credit_single", link_credit_o, 0);

        // Rx full: simultaneous push/pop, then a dropped push
        for (int k = 0; k < 4; k++) begin
            link_valid_i = 1'b1; link_data_i = 8'hB0 + 8'(k); tick;
        end
        link_data_i = 8'hEE; ready_i = 1'b1;
        chk("rx_full_head", data_o, 8'hB0);
        tick;
        chk("rx_pushpop_valid", valid_o, 1);
        chk("rx_pushpop_head", data_o, 8'hB1);
        chk("rx_pushpop_credit", link_credit_o, 1);
        link_data_i = 8'hFF; ready_i = 1'b0; tick;
        chk("rx_drop_no_credit", link_credit_o, 0);
        link_valid_i = 1'b0; ready_i = 1'b1;
        exp6[0] = 8'hB1; exp6[1] = 8'hB2; exp6[2] = 8'hB3; exp6[3] = 8'hEE;
        for (int k = 0; k < 4; k++) begin
            chk("rx_wrap_order", data_o, exp6[k]);
            tick;
        end
        chk("rx_drop_empty", valid_o, 0);
        ready_i = 1'b0;

        // Reset mid-operation
        link_credit_i = 1'b1; tick; link_credit_i = 1'b0;
        valid_i = 1'b1; data_i = 8'h77; link_valid_i = 1'b1; link_data_i = 8'hC0; tick;
        valid_i = 1'b0; link_data_i = 8'hC1; tick;
        link_valid_i = 1'b0;
        chk("mid_pre_valid", valid_o, 1);
        chk("mid_pre_ready", ready_o, 0);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_ready", ready_o, 1);
        chk("mid_rst_credit", link_credit_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1; ready_i = 1'b1;
        tick;
        chk("mid_post_valid", valid_o, 0);
        chk("mid_post_credit", link_credit_o, 0);
        ready_i = 1'b0;

        // Loopback: full-rate ready, then random ready
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 100; i++) flits[i] = 8'($urandom);
            tx_n = 0; rx_n = 0; stalls = 0; cyc = 0;
            while (rx_n < 100 && cyc < 2000) begin
                lb_ready = (p == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                if (lb_b_valid_o && lb_ready) begin
                    chk("lb_order", lb_b_data_o, flits[rx_n]);
                    rx_n++;
                end
                lb_valid = (tx_n < 100);
                lb_data = (tx_n < 100) ? flits[tx_n] : 8'h00;
                hs = lb_valid && lb_a_ready;
                if (p == 0 && tx_n > 0 && tx_n < 100 && !lb_a_ready) stalls++;
                tick;
                cyc++;
                if (hs) tx_n++;
            end
            lb_valid = 1'b0;
            chk("lb_count", rx_n, 100);
            if (p == 0) chk("lb_no_stall", stalls, 0);
        end

        // All four credits back at the sender
        lb_ready = 1'b1;
        repeat (4) tick;
        lb_ready = 1'b0;
        hs_n = 0;
        for (int i = 0; i < 6; i++) begin
            lb_valid = 1'b1; lb_data = 8'(i);
            if (lb_a_ready) hs_n++;
            tick;
        end
        lb_valid = 1'b0;
        chk("lb_credits_restored", hs_n, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
